// File: rtl/nios2_dbg_cmd_sequencer.sv
// nios2_dbg_cmd_sequencer: queues update-DR debug commands and replays them as
// one-hot take_action / take_no_action pulses, with optional consumer ack and ack timeout.
// Optional odd-parity screening of pushed commands: define NIOS2_DBG_CMD_PARITY_EN.

module nios2_dbg_cmd_slice #(
  parameter int CH   = 0,
  parameter int IR_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fire,
  input  logic            act,
  input  logic [IR_W-1:0] ir,
  output logic            take_action,
  output logic            take_no_action
);
  logic hit;
  assign hit = fire && (ir == IR_W'(CH));

  always_ff @(posedge clk) begin
    if (reset) begin
      take_action    <= 1'b0;
      take_no_action <= 1'b0;
    end else begin
      take_action    <= hit && act;
      take_no_action <= hit && !act;
    end
  end
endmodule

module nios2_dbg_cmd_sequencer #(
  parameter int                   DATA_W      = 38,
  parameter int                   IR_W        = 2,
  parameter int                   FIFO_DEPTH  = 4,
  parameter int                   ACT_BIT     = 35,
  parameter logic [2**IR_W-1:0]   ACK_MASK    = '1,
  parameter int                   ACK_TIMEOUT = 255
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            upd_valid,
  input  logic [IR_W-1:0]                 upd_ir,
  input  logic [DATA_W-1:0]               upd_data,
  output logic                            upd_ready,
  output logic [DATA_W-1:0]               jdo,
  output logic [2**IR_W-1:0]              take_action,
  output logic [2**IR_W-1:0]              take_no_action,
  input  logic                            ack,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH):0]     level,
  input  logic                            err_clr,
  output logic                            overflow,
  output logic                            timeout,
  output logic                            parity_err
);
  localparam int NCH = 2**IR_W;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int CW  = $clog2(ACK_TIMEOUT + 1);

  typedef struct packed {
    logic [IR_W-1:0]   ir;
    logic [DATA_W-1:0] data;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_t;

  cmd_t            mem [FIFO_DEPTH];
  cmd_t            rd_ent;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   cnt, cnt_nxt;
  state_t          state;
  logic [IR_W-1:0] cur_ir;
  logic            cur_act;
  logic [CW-1:0]   tmo_cnt;
  logic            par_ok, push, pop, ovf_ev, tmo_ev, fire;

`ifdef NIOS2_DBG_CMD_PARITY_EN
  logic par_ev;
  assign par_ok = ^upd_data;
  assign par_ev = upd_valid && upd_ready && !par_ok;

  always_ff @(posedge clk) begin
    if (reset) parity_err <= 1'b0;
    else       parity_err <= (parity_err && !err_clr) || par_ev;
  end
`else
  assign par_ok     = 1'b1;
  assign parity_err = 1'b0;
`endif

  // upd_ready is registered from the next occupancy, so a pop in a full
  // cycle never opens the door for a push in that same cycle.
  assign push   = upd_valid && upd_ready && par_ok;
  assign ovf_ev = upd_valid && !upd_ready;
  assign pop    = (state == IDLE) && (cnt != '0);
  assign rd_ent = mem[rd_ptr];
  assign level  = cnt;
  assign busy   = (state != IDLE) || (cnt != '0);
  assign fire   = (state == ISSUE);
  assign tmo_ev = (state == WAIT_ACK) && !ack && (tmo_cnt == CW'(ACK_TIMEOUT - 1));

  always_comb begin
    cnt_nxt = cnt;
    if (push && !pop)      cnt_nxt = cnt + LW'(1);
    else if (!push && pop) cnt_nxt = cnt - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_t'({upd_ir, upd_data});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      upd_ready <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt       <= cnt_nxt;
      upd_ready <= (cnt_nxt != LW'(FIFO_DEPTH));
      overflow  <= (overflow && !err_clr) || ovf_ev;
    end
  end

  // Ack sampled at the end of ISSUE already completes the command.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      jdo     <= '0;
      cur_ir  <= '0;
      cur_act <= 1'b0;
      tmo_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= (timeout && !err_clr) || tmo_ev;
      unique case (state)
        IDLE: begin
          if (pop) begin
            jdo     <= rd_ent.data;
            cur_ir  <= rd_ent.ir;
            cur_act <= rd_ent.data[ACT_BIT];
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          tmo_cnt <= '0;
          state   <= (ACK_MASK[cur_ir] && !ack) ? WAIT_ACK : IDLE;
        end
        WAIT_ACK: begin
          if (ack || tmo_ev) state <= IDLE;
          else               tmo_cnt <= tmo_cnt + CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    nios2_dbg_cmd_slice #(.CH(c), .IR_W(IR_W)) u_slice (
      .clk            (clk),
      .reset          (reset),
      .fire           (fire),
      .act            (cur_act),
      .ir             (cur_ir),
      .take_action    (take_action[c]),
      .take_no_action (take_no_action[c])
    );
  end
endmodule
